layer_norm_seq_ctrl: RTL and testbench

//  Sequencer for the spiking layer-norm datapath (per-time-step alpha/beta ROMs + 16-lane threshold).

---
 rtl/layer_norm_seq_ctrl_if.sv | 39 +++
 rtl/layer_norm_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_layer_norm_seq_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_norm_seq_ctrl_if.sv
// Bundle of every non-clock/reset signal of the layer-norm sequencer.
//  slave  : controller side (layer_norm_seq_ctrl)
//  master : environment side (upstream source, ROM/datapath, downstream sink)
// Groups: run control (start, blk_first, blk_last, busy, done, cfg_err),
//         upstream stream (in_*), datapath/ROM (norm_*), output FIFO head (out_*).
interface layer_norm_seq_ctrl_if #(parameter int DW = 16);
  logic          start;
  logic [2:0]    blk_first;
  logic [2:0]    blk_last;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          norm_ena;
  logic [2:0]    norm_sel;
  logic [4:0]    norm_tstep;
  logic [DW-1:0] norm_data;
  logic          norm_valid;
  logic [DW-1:0] norm_out;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    out_blk;
  logic [4:0]    out_tstep;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          cfg_err;

  modport slave (
    input  start, blk_first, blk_last, in_valid, in_data, norm_out, out_ready,
    output in_ready, norm_ena, norm_sel, norm_tstep, norm_data, norm_valid,
           out_valid, out_data, out_blk, out_tstep, busy, done, cfg_err
  );

  modport master (
    output start, blk_first, blk_last, in_valid, in_data, norm_out, out_ready,
    input  in_ready, norm_ena, norm_sel, norm_tstep, norm_data, norm_valid,
           out_valid, out_data, out_blk, out_tstep, busy, done, cfg_err
  );
endinterface

// File: rtl/layer_norm_seq_ctrl.sv
// Sequencer for the spiking layer-norm datapath.
// Walks blocks blk_first..blk_last; per block accepts T_STEPS upstream spike
// vectors, issues ROM block/time-step address on each accepted beat, delays
// the vector ROM_LAT cycles so it meets the ROM output at the datapath, and
// captures the datapath result into a 2-entry output FIFO.
// Ports: clk, rst (sync, active-high), bus (layer_norm_seq_ctrl_if.slave):
//  start/blk_first/blk_last in, busy/done/cfg_err out; in_valid/in_data in,
//  in_ready out; norm_ena/sel/tstep/data/valid out, norm_out in;
//  out_valid/data/blk/tstep out, out_ready in.
module layer_norm_seq_ctrl #(
  parameter int DW         = 16,
  parameter int T_STEPS    = 30,
  parameter int NUM_BLOCKS = 6,
  parameter int ROM_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  layer_norm_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    blk;
    logic [4:0]    tstep;
  } beat_t;

  state_t      state, state_nxt;
  logic [2:0]  cur_blk, last_blk;
  logic [4:0]  tstep;
  logic        cfg_err;

  // vld_pipe[ROM_LAT] is the beat reaching the datapath this cycle
  logic [ROM_LAT:1] vld_pipe;
  beat_t            beat_pipe [1:ROM_LAT];

  beat_t       fifo_mem [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  fifo_cnt;

  logic        accept, push, pop, last_beat, cfg_bad, start_ok;
  logic [2:0]  inflight;
  logic [3:0]  occ;

  assign pop       = (fifo_cnt != 2'd0) & bus.out_ready;
  assign push      = vld_pipe[ROM_LAT];
  assign cfg_bad   = (bus.blk_first > bus.blk_last) || (32'(bus.blk_last) >= NUM_BLOCKS);
  assign start_ok  = (state == IDLE) & bus.start & ~cfg_bad;

  always_comb begin
    inflight = '0;
    for (int i = 1; i <= ROM_LAT; i++) inflight = inflight + 3'(vld_pipe[i]);
  end

  // Credit: every in-flight beat already owns a FIFO slot, so the FIFO can
  // never be asked to take a third entry. A pop this cycle frees one credit.
  assign occ          = {2'b0, fifo_cnt} + {1'b0, inflight};
  assign bus.in_ready = (state == RUN) && (occ < (4'd2 + {3'b0, pop}));
  assign accept       = bus.in_valid & bus.in_ready;
  assign last_beat    = accept && (cur_blk == last_blk) && (tstep == 5'(T_STEPS - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_ok) state_nxt = RUN;
      RUN:   if (last_beat) state_nxt = DRAIN;
      // move on when the FIFO will be empty after this edge, so done lands
      // the cycle right after the final pop
      DRAIN: if (inflight == 3'd0 && fifo_cnt == {1'b0, pop}) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_blk  <= '0;
      last_blk <= '0;
      tstep    <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if ((state == IDLE) && bus.start) cfg_err <= cfg_bad;
      if (start_ok) begin
        cur_blk  <= bus.blk_first;
        last_blk <= bus.blk_last;
        tstep    <= '0;
      end else if (accept) begin
        if (tstep == 5'(T_STEPS - 1)) begin
          tstep   <= '0;
          cur_blk <= cur_blk + 3'd1;
        end else begin
          tstep <= tstep + 5'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 1; i <= ROM_LAT; i++) beat_pipe[i] <= '0;
    end else begin
      vld_pipe[1]  <= accept;
      beat_pipe[1] <= '{data: bus.in_data, blk: cur_blk, tstep: tstep};
      for (int i = 2; i <= ROM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        beat_pipe[i] <= beat_pipe[i-1];
      end
    end
  end

  // Push+pop at count 2 writes the slot being read out; the head value
  // seen this cycle is the old one, and rd_ptr moves off it at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      fifo_cnt    <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= '{data: bus.norm_out, blk: beat_pipe[ROM_LAT].blk,
                              tstep: beat_pipe[ROM_LAT].tstep};
        wr_ptr <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign bus.norm_ena   = accept;
  assign bus.norm_sel   = cur_blk;
  assign bus.norm_tstep = tstep;
  assign bus.norm_valid = vld_pipe[ROM_LAT];
  assign bus.norm_data  = beat_pipe[ROM_LAT].data;
  assign bus.out_valid  = (fifo_cnt != 2'd0);
  assign bus.out_data   = fifo_mem[rd_ptr].data;
  assign bus.out_blk    = fifo_mem[rd_ptr].blk;
  assign bus.out_tstep  = fifo_mem[rd_ptr].tstep;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.cfg_err    = cfg_err;

endmodule

// File: tb/tb_layer_norm_seq_ctrl.sv
// Directed bench for layer_norm_seq_ctrl. Instance a uses ROM_LAT=1
// (reset, single/multi block, backpressure, config error); instance b uses
// ROM_LAT=3 (alignment with gapped input). The ROM/datapath is modelled here:
// ROM word = rom(blk,tstep) read ROM_LAT cycles after the address is issued,
// datapath result = vector ^ ROM word.
module tb_layer_norm_seq_ctrl;
  localparam int T = 30;

  typedef struct packed {
    logic [15:0] d;
    logic [2:0]  b;
    logic [4:0]  t;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  layer_norm_seq_ctrl_if #(.DW(16)) a ();
  layer_norm_seq_ctrl_if #(.DW(16)) b ();

  layer_norm_seq_ctrl #(.DW(16), .T_STEPS(T), .NUM_BLOCKS(6), .ROM_LAT(1))
    dut_a (.clk(clk), .rst(rst), .bus(a));
  layer_norm_seq_ctrl #(.DW(16), .T_STEPS(T), .NUM_BLOCKS(6), .ROM_LAT(3))
    dut_b (.clk(clk), .rst(rst), .bus(b));

  function automatic logic [15:0] rom(input logic [2:0] bk, input logic [4:0] ts);
    return {ts, bk, ~bk, ~ts};
  endfunction

  function automatic logic [15:0] pat(input int n);
    return 16'(n * 40503 + 4660);
  endfunction

  // ROM models: address registered ROM_LAT times
  logic [7:0] rom_a;
  logic [7:0] rom_b0, rom_b1, rom_b2;
  always @(posedge clk) begin
    rom_a  <= {a.norm_sel, a.norm_tstep};
    rom_b0 <= {b.norm_sel, b.norm_tstep};
    rom_b1 <= rom_b0;
    rom_b2 <= rom_b1;
  end
  assign a.norm_out = a.norm_data ^ rom(rom_a[7:5], rom_a[4:0]);
  assign b.norm_out = b.norm_data ^ rom(rom_b2[7:5], rom_b2[4:0]);

  int total = 0;
  int bad   = 0;
  ent_t qa[$];
  ent_t qb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input bit on_b, input logic [2:0] bf, input logic [2:0] bl);
    @(posedge clk); #1;
    if (on_b) begin b.start = 1'b1; b.blk_first = bf; b.blk_last = bl; end
    else      begin a.start = 1'b1; a.blk_first = bf; a.blk_last = bl; end
    @(posedge clk); #1;
    a.start = 1'b0;
    b.start = 1'b0;
  endtask

  // Feed nb beats into instance a starting at block bf, hold out_ready low for
  // bp_len cycles from cycle bp_at, and score everything that comes out.
  task automatic run_a(input string nm, input int nb, input logic [2:0] bf,
                       input int bp_at, input int bp_len, input bit lat_chk);
    int sent = 0, pops = 0, dones = 0, cyc = 0, last_pop = -10, done_cyc = -100;
    bit hold = 0, acc1 = 0, acc2 = 0, acc;
    logic [23:0] prev_head = '0;
    logic [2:0]  eb;
    logic [4:0]  et;
    ent_t e;
    qa.delete();
    while (dones == 0 && cyc < 2000) begin
      @(posedge clk); #1;
      a.in_valid  = (sent < nb);
      a.in_data   = pat(sent);
      a.out_ready = !(cyc >= bp_at && cyc < bp_at + bp_len);
      @(negedge clk);
      acc = a.in_valid & a.in_ready;
      if (acc) begin
        eb = 3'(bf + sent / T);
        et = 5'(sent % T);
        chk({nm, "_norm_ena"}, a.norm_ena, 1);
        chk({nm, "_norm_sel"}, a.norm_sel, eb);
        chk({nm, "_norm_tstep"}, a.norm_tstep, et);
        qa.push_back('{d: a.in_data ^ rom(eb, et), b: eb, t: et});
        sent++;
      end
      if (hold) chk({nm, "_head_stable"}, {a.out_data, a.out_blk, a.out_tstep}, prev_head);
      if (lat_chk) chk({nm, "_out_lat"}, a.out_valid, acc2);
      if (cyc > bp_at && cyc < bp_at + bp_len) begin
        chk({nm, "_bp_in_ready"}, a.in_ready, 0);
        chk({nm, "_bp_out_valid"}, a.out_valid, 1);
      end
      if (a.out_valid && a.out_ready) begin
        if (qa.size() == 0) chk({nm, "_pop_unexpected"}, 1, 0);
        else begin
          e = qa.pop_front();
          chk({nm, "_out_head"}, {a.out_data, a.out_blk, a.out_tstep}, {e.d, e.b, e.t});
        end
        pops++;
        last_pop = cyc;
      end
      chk({nm, "_occupancy"}, 32'((sent - pops) <= 2), 1);
      if (a.done) begin dones++; done_cyc = cyc; end
      hold      = a.out_valid & ~a.out_ready;
      prev_head = {a.out_data, a.out_blk, a.out_tstep};
      acc2 = acc1;
      acc1 = acc;
      cyc++;
    end
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1;
    chk({nm, "_done_seen"}, dones, 1);
    chk({nm, "_pops"}, pops, nb);
    chk({nm, "_accepts"}, sent, nb);
    chk({nm, "_done_after_pop"}, done_cyc - last_pop, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({nm, "_idle_busy"}, a.busy, 0);
      chk({nm, "_idle_done"}, a.done, 0);
    end
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sent, pops, dones, cyc;
    bit h0, h1, h2, acc;
    logic [15:0] d0, d1, d2;
    logic [2:0] eb;
    logic [4:0] et;
    bit [7:0] gap;
    ent_t e;

    a.start = 0; a.blk_first = 0; a.blk_last = 0; a.in_valid = 0; a.in_data = 0; a.out_ready = 1;
    b.start = 0; b.blk_first = 0; b.blk_last = 0; b.in_valid = 0; b.in_data = 0; b.out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", a.in_ready, 0);
    chk("rst_busy", a.busy, 0);
    chk("rst_done", a.done, 0);
    chk("rst_out_valid", a.out_valid, 0);
    chk("rst_norm_valid", a.norm_valid, 0);
    chk("rst_cfg_err", a.cfg_err, 0);
    chk("rst_out_data", {a.out_data, a.out_blk, a.out_tstep}, 0);

    // T1: reset mid-run
    do_start(0, 3'd0, 3'd5);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a.in_valid = 1'b1;
      a.in_data  = pat(i);
      @(negedge clk);
      chk("t1_no_done_run", a.done, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t1_rst_busy", a.busy, 0);
    chk("t1_rst_in_ready", a.in_ready, 0);
    chk("t1_rst_out_valid", a.out_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_in_ready", a.in_ready, 0);
      chk("t1_norm_ena", a.norm_ena, 0);
      chk("t1_norm_valid", a.norm_valid, 0);
      chk("t1_out_valid", a.out_valid, 0);
      chk("t1_busy", a.busy, 0);
      chk("t1_done", a.done, 0);
      chk("t1_norm_sel", {a.norm_sel, a.norm_tstep}, 0);
    end
    a.in_valid = 1'b0;

    // T2: single block 2
    do_start(0, 3'd2, 3'd2);
    chk("t2_busy", a.busy, 1);
    run_a("t2", 30, 3'd2, 100000, 0, 1);

    // T3: blocks 0..5
    do_start(0, 3'd0, 3'd5);
    run_a("t3", 180, 3'd0, 100000, 0, 0);

    // T4: backpressure mid-block
    do_start(0, 3'd3, 3'd3);
    run_a("t4", 30, 3'd3, 8, 10, 0);

    // T5: config errors
    do_start(0, 3'd4, 3'd1);
    chk("t5_err_order", a.cfg_err, 1);
    chk("t5_idle_order", a.busy, 0);
    do_start(0, 3'd6, 3'd6);
    chk("t5_err_range", a.cfg_err, 1);
    chk("t5_idle_range", a.busy, 0);
    do_start(0, 3'd0, 3'd0);
    chk("t5_err_clear", a.cfg_err, 0);
    chk("t5_busy", a.busy, 1);
    run_a("t5", 30, 3'd0, 100000, 0, 0);

    // T6: ROM_LAT=3, gapped input on blocks 1..2
    do_start(1, 3'd1, 3'd2);
    qb.delete();
    sent = 0; pops = 0; dones = 0; cyc = 0;
    h0 = 0; h1 = 0; h2 = 0; d0 = 0; d1 = 0; d2 = 0;
    gap = 8'b1011_0111;
    while (dones == 0 && cyc < 3000) begin
      @(posedge clk); #1;
      b.in_valid  = (sent < 60) && gap[cyc % 8];
      b.in_data   = ~pat(sent);
      b.out_ready = (cyc % 5 != 3);
      @(negedge clk);
      acc = b.in_valid & b.in_ready;
      chk("t6_norm_valid", b.norm_valid, h2);
      if (h2) chk("t6_norm_data", b.norm_data, d2);
      if (acc) begin
        eb = 3'(1 + sent / T);
        et = 5'(sent % T);
        chk("t6_norm_addr", {b.norm_sel, b.norm_tstep}, {eb, et});
        qb.push_back('{d: b.in_data ^ rom(eb, et), b: eb, t: et});
        sent++;
      end
      if (b.out_valid && b.out_ready) begin
        if (qb.size() == 0) chk("t6_pop_unexpected", 1, 0);
        else begin
          e = qb.pop_front();
          chk("t6_out_head", {b.out_data, b.out_blk, b.out_tstep}, {e.d, e.b, e.t});
        end
        pops++;
      end
      if (b.done) dones++;
      h2 = h1; h1 = h0; h0 = acc;
      d2 = d1; d1 = d0; d0 = b.in_data;
      cyc++;
    end
    b.in_valid = 1'b0;
    chk("t6_done_seen", dones, 1);
    chk("t6_pops", pops, 60);
    chk("t6_accepts", sent, 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
